// File: rtl/mux_seq_pkg.sv
// Shared types, default timing and the channel decode helper for the mux
// switch sequencer.
// No ports: imported by mux_bank_decode and mux_switch_sequencer.
package mux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        ADDR,
        MAKE
    } seq_state_t;

    localparam int unsigned DEF_N_CH      = 48;
    localparam int unsigned DEF_BANK_SIZE = 16;
    localparam int unsigned DEF_T_BREAK   = 12;
    localparam int unsigned DEF_T_ADDR    = 19;
    localparam int unsigned DEF_T_EN      = 12;

    typedef struct packed {
        logic [7:0] bank;
        logic [7:0] addr;
        logic       in_range;
    } chan_split_t;

    // Channel -> {bank, address within bank, valid}. bank_size is a power of
    // two, so the division/modulo reduce to a bit split.
    function automatic chan_split_t chan_split(input logic [7:0]  ch,
                                               input int unsigned bank_size,
                                               input int unsigned n_ch);
        chan_split_t r;
        int unsigned c;
        c          = {24'd0, ch};
        r.bank     = 8'(c / bank_size);
        r.addr     = 8'(c % bank_size);
        r.in_range = (c < n_ch);
        return r;
    endfunction

endpackage

// File: rtl/mux_bank_decode.sv
// Registered channel decoder: holds a bank index and address and drives a
// one-hot bank enable on command from the sequencer.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   ch_i           channel to decode (sampled when load_i is high)
//   load_i         capture a new address/bank from ch_i
//   en_set_i       drive the one-hot enable for the held bank
//   en_clr_i       force all enables low (wins over en_set_i)
//   bank_en_o      one-hot bank enable (all zero if held channel out of range)
//   addr_o         address within bank
module mux_bank_decode
    import mux_seq_pkg::*;
#(
    parameter  int unsigned N_CH      = DEF_N_CH,
    parameter  int unsigned BANK_SIZE = DEF_BANK_SIZE,
    localparam int unsigned CHW       = $clog2(N_CH),
    localparam int unsigned N_OUT     = N_CH / BANK_SIZE,
    localparam int unsigned AW        = (BANK_SIZE > 1) ? $clog2(BANK_SIZE) : 1,
    localparam int unsigned BW        = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CHW-1:0]   ch_i,
    input  logic             load_i,
    input  logic             en_set_i,
    input  logic             en_clr_i,
    output logic [N_OUT-1:0] bank_en_o,
    output logic [AW-1:0]    addr_o
);

    chan_split_t      split;
    logic [BW-1:0]    bank_q, bank_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             valid_q, valid_d;
    logic [N_OUT-1:0] en_q, en_d;

    always_comb begin
        split   = chan_split(8'(ch_i), BANK_SIZE, N_CH);
        bank_d  = bank_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        en_d    = en_q;
        if (load_i) begin
            valid_d = split.in_range;
            // Out-of-range loads leave the previous address on the pins.
            if (split.in_range) begin
                bank_d = BW'(split.bank);
                addr_d = AW'(split.addr);
            end
        end
        if (en_clr_i) begin
            en_d = '0;
        end else if (en_set_i) begin
            en_d = '0;
            if (valid_q) begin
                en_d[bank_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bank_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            en_q    <= '0;
        end else begin
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            en_q    <= en_d;
        end
    end

    assign bank_en_o = en_q;
    assign addr_o    = addr_q;

endmodule

// File: rtl/mux_switch_sequencer.sv
// Break-before-make sequencer for the sender enables and the P/N analog mux
// banks. A request is captured on valid&ready, then: all enables off for
// T_BREAK, new addresses for T_ADDR, enables on for T_EN, then settled.
// Ports:
//   clock, reset             system clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only while idle)
//   req_off                  request all paths off (channel fields ignored)
//   req_snd, req_p, req_n    sender / P receive / N receive channel
//   en_snd                   one-hot sender enable
//   mux_p_en, mux_p_addr     P bank one-hot enable and address
//   mux_n_en, mux_n_addr     N bank one-hot enable and address
//   settled                  outputs reflect the last accepted request
//   range_err                one-cycle pulse on acceptance of an out-of-range channel
module mux_switch_sequencer
    import mux_seq_pkg::*;
#(
    parameter  int unsigned N_CH      = DEF_N_CH,
    parameter  int unsigned BANK_SIZE = DEF_BANK_SIZE,
    parameter  int unsigned T_BREAK   = DEF_T_BREAK,
    parameter  int unsigned T_ADDR    = DEF_T_ADDR,
    parameter  int unsigned T_EN      = DEF_T_EN,
    localparam int unsigned CHW       = $clog2(N_CH),
    localparam int unsigned N_BANKS   = N_CH / BANK_SIZE,
    localparam int unsigned AW        = $clog2(BANK_SIZE)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_off,
    input  logic [CHW-1:0]     req_snd,
    input  logic [CHW-1:0]     req_p,
    input  logic [CHW-1:0]     req_n,
    output logic [N_CH-1:0]    en_snd,
    output logic [N_BANKS-1:0] mux_p_en,
    output logic [AW-1:0]      mux_p_addr,
    output logic [N_BANKS-1:0] mux_n_en,
    output logic [AW-1:0]      mux_n_addr,
    output logic               settled,
    output logic               range_err
);

    localparam int unsigned T_MAX0 = (T_BREAK > T_ADDR) ? T_BREAK : T_ADDR;
    localparam int unsigned T_MAX  = (T_MAX0 > T_EN) ? T_MAX0 : T_EN;
    localparam int unsigned CW     = $clog2(T_MAX + 1);

    seq_state_t     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ready_q, ready_d;
    logic           settled_q, settled_d;
    logic           rerr_q, rerr_d;
    logic           off_q, off_d;
    logic [CHW-1:0] snd_q, snd_d, p_q, p_d, n_q, n_d;

    logic           accept, same_req, req_bad;
    logic           dec_load, dec_set, dec_clr;
    chan_split_t    sp_snd, sp_p, sp_n;
    logic           snd_addr_unused;

    always_comb begin
        sp_snd   = chan_split(8'(req_snd), 1, N_CH);
        sp_p     = chan_split(8'(req_p), BANK_SIZE, N_CH);
        sp_n     = chan_split(8'(req_n), BANK_SIZE, N_CH);
        req_bad  = !req_off && !(sp_snd.in_range && sp_p.in_range && sp_n.in_range);
        accept   = req_valid && ready_q;
        same_req = settled_q && (req_off == off_q) &&
                   (req_off || (req_snd == snd_q && req_p == p_q && req_n == n_q));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        settled_d = settled_q;
        rerr_d    = 1'b0;
        off_d     = off_q;
        snd_d     = snd_q;
        p_d       = p_q;
        n_d       = n_q;
        dec_load  = 1'b0;
        dec_set   = 1'b0;
        dec_clr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Ready always returns high one cycle after a fast-path accept.
                ready_d = 1'b1;
                if (accept) begin
                    rerr_d  = req_bad;
                    ready_d = 1'b0;
                    // An identical request while settled is acknowledged
                    // without touching any path.
                    if (!same_req) begin
                        off_d     = req_off;
                        snd_d     = req_snd;
                        p_d       = req_p;
                        n_d       = req_n;
                        settled_d = 1'b0;
                        dec_clr   = 1'b1;
                        state_d   = BREAK;
                        cnt_d     = CW'(T_BREAK - 1);
                    end
                end
            end
            BREAK: begin
                if (cnt_q == '0) begin
                    if (off_q) begin
                        state_d   = IDLE;
                        ready_d   = 1'b1;
                        settled_d = 1'b1;
                    end else begin
                        state_d  = ADDR;
                        cnt_d    = CW'(T_ADDR - 1);
                        dec_load = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ADDR: begin
                if (cnt_q == '0) begin
                    state_d = MAKE;
                    cnt_d   = CW'(T_EN - 1);
                    dec_set = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            MAKE: begin
                if (cnt_q == '0) begin
                    state_d   = IDLE;
                    ready_d   = 1'b1;
                    settled_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            settled_q <= 1'b0;
            rerr_q    <= 1'b0;
            off_q     <= 1'b0;
            snd_q     <= '0;
            p_q       <= '0;
            n_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            settled_q <= settled_d;
            rerr_q    <= rerr_d;
            off_q     <= off_d;
            snd_q     <= snd_d;
            p_q       <= p_d;
            n_q       <= n_d;
        end
    end

    // Sender side: one "bank" per channel gives a full one-hot enable.
    mux_bank_decode #(
        .N_CH      (N_CH),
        .BANK_SIZE (1)
    ) u_dec_snd (
        .clk_i     (clock),
        .rst_i     (reset),
        .ch_i      (snd_q),
        .load_i    (dec_load),
        .en_set_i  (dec_set),
        .en_clr_i  (dec_clr),
        .bank_en_o (en_snd),
        .addr_o    (snd_addr_unused)
    );

    mux_bank_decode #(
        .N_CH      (N_CH),
        .BANK_SIZE (BANK_SIZE)
    ) u_dec_p (
        .clk_i     (clock),
        .rst_i     (reset),
        .ch_i      (p_q),
        .load_i    (dec_load),
        .en_set_i  (dec_set),
        .en_clr_i  (dec_clr),
        .bank_en_o (mux_p_en),
        .addr_o    (mux_p_addr)
    );

    mux_bank_decode #(
        .N_CH      (N_CH),
        .BANK_SIZE (BANK_SIZE)
    ) u_dec_n (
        .clk_i     (clock),
        .rst_i     (reset),
        .ch_i      (n_q),
        .load_i    (dec_load),
        .en_set_i  (dec_set),
        .en_clr_i  (dec_clr),
        .bank_en_o (mux_n_en),
        .addr_o    (mux_n_addr)
    );

    assign req_ready = ready_q;
    assign settled   = settled_q;
    assign range_err = rerr_q;

endmodule

// File: tb/tb_mux_switch_sequencer.sv
// Bench for mux_switch_sequencer (N_CH=48, default timing).
module tb_mux_switch_sequencer;

    localparam int unsigned T_BREAK = 12;
    localparam int unsigned T_ADDR  = 19;
    localparam int unsigned T_EN    = 12;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_off = 1'b0;
    logic [5:0]  req_snd = '0, req_p = '0, req_n = '0;
    logic        req_ready, settled, range_err;
    logic [47:0] en_snd;
    logic [2:0]  mux_p_en, mux_n_en;
    logic [3:0]  mux_p_addr, mux_n_addr;

    always #5 clock = ~clock;

    mux_switch_sequencer #(
        .N_CH      (48),
        .BANK_SIZE (16),
        .T_BREAK   (T_BREAK),
        .T_ADDR    (T_ADDR),
        .T_EN      (T_EN)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_off    (req_off),
        .req_snd    (req_snd),
        .req_p      (req_p),
        .req_n      (req_n),
        .en_snd     (en_snd),
        .mux_p_en   (mux_p_en),
        .mux_p_addr (mux_p_addr),
        .mux_n_en   (mux_n_en),
        .mux_n_addr (mux_n_addr),
        .settled    (settled),
        .range_err  (range_err)
    );

    typedef struct packed {
        logic [47:0] snd;
        logic [2:0]  pe;
        logic [3:0]  pa;
        logic [2:0]  ne;
        logic [3:0]  na;
        logic        st;
        logic        rdy;
        logic        rerr;
    } outs_t;

    typedef struct {
        logic        off;
        int          snd, p, n;
        logic [47:0] e_snd;
        logic [2:0]  e_pe;
        logic [3:0]  e_pa;
        logic        chk_pa;
        logic [2:0]  e_ne;
        logic [3:0]  e_na;
    } vec_t;

    int passed = 0;
    int total  = 0;
    int viol   = 0;

    // Reference model state: outputs while idle plus the last captured request.
    outs_t m;
    logic  pk, nk;               // P/N address known (unknown after out-of-range)
    logic  cur_off;
    int    cur_snd, cur_p, cur_n;
    outs_t RST_O;

    function automatic outs_t dut_outs();
        return {en_snd, mux_p_en, mux_p_addr, mux_n_en, mux_n_addr, settled, req_ready, range_err};
    endfunction

    function automatic logic [47:0] snd_vec(int ch);
        return (ch < 48) ? (48'd1 << ch) : 48'd0;
    endfunction

    function automatic logic [2:0] bank_vec(int ch);
        return (ch < 48) ? (3'd1 << (ch / 16)) : 3'd0;
    endfunction

    task automatic check(input string name, input outs_t exp_i, input logic chk_pa, input logic chk_na);
        outs_t got, exp;
        got = dut_outs();
        exp = exp_i;
        if (!chk_pa) begin got.pa = '0; exp.pa = '0; end
        if (!chk_na) begin got.na = '0; exp.na = '0; end
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got snd=%h pe=%b pa=%0d ne=%b na=%0d st=%b rdy=%b rerr=%b, expected snd=%h pe=%b pa=%0d ne=%b na=%0d st=%b rdy=%b rerr=%b",
                      name, got.snd, got.pe, got.pa, got.ne, got.na, got.st, got.rdy, got.rerr,
                      exp.snd, exp.pe, exp.pa, exp.ne, exp.na, exp.st, exp.rdy, exp.rerr);
    endtask

    task automatic model_reset();
        m = RST_O; pk = 1'b1; nk = 1'b1;
        cur_off = 1'b0; cur_snd = 0; cur_p = 0; cur_n = 0;
    endtask

    // Issue one request from idle and check every cycle until the sequencer
    // is ready again. Inputs are scrambled while busy; they must be ignored.
    task automatic run_request(input logic off, input int snd, input int p, input int n, input string tag);
        outs_t       fin, exp;
        logic        same, rerr, pk_new, nk_new, apk, ank;
        int unsigned len;
        same = m.st && (off == cur_off) && (off || (snd == cur_snd && p == cur_p && n == cur_n));
        rerr = !off && (snd >= 48 || p >= 48 || n >= 48);
        fin = m; fin.st = 1'b1; fin.rdy = 1'b1; fin.rerr = 1'b0;
        pk_new = pk; nk_new = nk;
        if (!same) begin
            if (off) begin
                fin.snd = '0; fin.pe = '0; fin.ne = '0;
            end else begin
                fin.snd = snd_vec(snd); fin.pe = bank_vec(p); fin.ne = bank_vec(n);
                if (p < 48) begin fin.pa = 4'(p % 16); pk_new = 1'b1; end else pk_new = 1'b0;
                if (n < 48) begin fin.na = 4'(n % 16); nk_new = 1'b1; end else nk_new = 1'b0;
            end
        end
        len = same ? 2 : (off ? 1 + T_BREAK : 1 + T_BREAK + T_ADDR + T_EN);
        req_valid = 1'b1; req_off = off;
        req_snd = 6'(snd); req_p = 6'(p); req_n = 6'(n);
        @(posedge clock); #1;
        for (int unsigned c = 1; c <= len; c++) begin
            exp = m; apk = pk; ank = nk;
            exp.rerr = (c == 1) && rerr;
            if (same) begin
                exp.rdy = (c == len);
            end else if (c == len) begin
                exp = fin; apk = pk_new; ank = nk_new;
            end else begin
                exp.snd = '0; exp.pe = '0; exp.ne = '0; exp.st = 1'b0; exp.rdy = 1'b0;
                if (!off && c >= 1 + T_BREAK) begin
                    exp.pa = fin.pa; exp.na = fin.na; apk = pk_new; ank = nk_new;
                end
                if (!off && c >= 1 + T_BREAK + T_ADDR) begin
                    exp.snd = fin.snd; exp.pe = fin.pe; exp.ne = fin.ne;
                end
            end
            check($sformatf("%s c%0d", tag, c), exp, apk, ank);
            if (c < len) begin
                req_valid = 1'($urandom); req_off = 1'($urandom);
                req_snd = 6'($urandom); req_p = 6'($urandom); req_n = 6'($urandom);
                @(posedge clock); #1;
            end else begin
                req_valid = 1'b0;
            end
        end
        m = fin; pk = pk_new; nk = nk_new;
        if (!same) begin
            cur_off = off; cur_snd = snd; cur_p = p; cur_n = n;
        end
    endtask

    // Address and enable must never change together (reset excepted).
    outs_t prev_o;
    always @(negedge clock) begin
        outs_t now_o;
        now_o = dut_outs();
        if (!reset) begin
            if ((now_o.snd != prev_o.snd || now_o.pe != prev_o.pe || now_o.ne != prev_o.ne) &&
                (now_o.pa != prev_o.pa || now_o.na != prev_o.na))
                viol++;
        end
        prev_o = now_o;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[9];
        outs_t e;

        RST_O = '0; RST_O.rdy = 1'b1;
        model_reset();

        vecs[0] = '{1'b0, 5, 3, 20,  48'd1 << 5,  3'b001, 4'd3,  1'b1, 3'b010, 4'd4};
        vecs[1] = '{1'b0, 5, 35, 20, 48'd1 << 5,  3'b100, 4'd3,  1'b1, 3'b010, 4'd4};
        vecs[2] = '{1'b0, 5, 35, 20, 48'd1 << 5,  3'b100, 4'd3,  1'b1, 3'b010, 4'd4};
        vecs[3] = '{1'b0, 5, 50, 20, 48'd1 << 5,  3'b000, 4'd0,  1'b0, 3'b010, 4'd4};
        vecs[4] = '{1'b0, 47, 0, 47, 48'd1 << 47, 3'b001, 4'd0,  1'b1, 3'b100, 4'd15};
        vecs[5] = '{1'b1, 9, 9, 9,   48'd0,       3'b000, 4'd0,  1'b1, 3'b000, 4'd15};
        vecs[6] = '{1'b1, 1, 2, 3,   48'd0,       3'b000, 4'd0,  1'b1, 3'b000, 4'd15};
        vecs[7] = '{1'b0, 0, 15, 16, 48'd1,       3'b001, 4'd15, 1'b1, 3'b010, 4'd0};
        vecs[8] = '{1'b0, 63, 16, 31, 48'd0,      3'b010, 4'd0,  1'b1, 3'b010, 4'd15};

        // Asynchronous reset takes effect with no clock edge.
        #2 reset = 1'b1;
        #1 check("reset_async", RST_O, 1'b1, 1'b1);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("reset_release", RST_O, 1'b1, 1'b1);
        for (int unsigned i = 0; i < 100; i++) begin
            @(posedge clock); #1;
            check($sformatf("idle%0d", i), RST_O, 1'b1, 1'b1);
        end

        foreach (vecs[i]) begin
            run_request(vecs[i].off, vecs[i].snd, vecs[i].p, vecs[i].n, $sformatf("vec%0d", i));
            e = '{snd: vecs[i].e_snd, pe: vecs[i].e_pe, pa: vecs[i].e_pa, ne: vecs[i].e_ne,
                  na: vecs[i].e_na, st: 1'b1, rdy: 1'b1, rerr: 1'b0};
            check($sformatf("vec%0d_final", i), e, vecs[i].chk_pa, 1'b1);
            @(posedge clock); #1;
            check($sformatf("vec%0d_hold", i), e, vecs[i].chk_pa, 1'b1);
        end

        // Reset in the middle of a sequence (cycle 20: new addresses, enables off).
        req_valid = 1'b1; req_off = 1'b0; req_snd = 6'd7; req_p = 6'd8; req_n = 6'd9;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (19) begin @(posedge clock); #1; end
        e = '{snd: '0, pe: '0, pa: 4'd8, ne: '0, na: 4'd9, st: 1'b0, rdy: 1'b0, rerr: 1'b0};
        check("midseq_c20", e, 1'b1, 1'b1);
        #2 reset = 1'b1;
        #1 check("midseq_reset_async", RST_O, 1'b1, 1'b1);
        @(posedge clock); #1;
        check("midseq_reset_held", RST_O, 1'b1, 1'b1);
        reset = 1'b0;
        model_reset();
        @(posedge clock); #1;
        check("midseq_released", RST_O, 1'b1, 1'b1);
        run_request(1'b0, 5, 3, 20, "post_reset");

        // Randomised requests: new, identical, off, out of range.
        for (int unsigned i = 0; i < 60; i++) begin
            int unsigned kind;
            kind = $urandom_range(0, 9);
            if (kind == 0)
                run_request(1'b1, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63), "rnd_off");
            else if (kind <= 2 && m.st)
                run_request(cur_off, cur_snd, cur_p, cur_n, "rnd_same");
            else
                run_request(1'b0, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63), "rnd_new");
            repeat ($urandom_range(0, 3)) begin
                @(posedge clock); #1;
                check("rnd_idle", m, pk, nk);
            end
        end

        total++;
        if (viol == 0) passed++;
        else $display("FAIL addr_en_coincidence: got %0d coincident changes, expected 0", viol);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
